vc_output_scheduler: RTL

//  Round-robin, credit-based scheduler that drains NUM_VC virtual-channel FIFOs (8-bit flits) onto a

---
 rtl/vc_output_scheduler_pkg.sv | 15 +
 rtl/vc_output_scheduler_rr_pick.sv | 31 +++
 rtl/vc_output_scheduler.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/vc_output_scheduler_pkg.sv
// Shared types and defaults for the VC output scheduler and its picker.
// Imported by every file of the output-port scheduler slice.
package vc_output_scheduler_pkg;

  localparam int FLIT_W_DEF     = 8;
  localparam int NUM_VC_DEF     = 4;
  localparam int CREDIT_MAX_DEF = 8;
  localparam int MAX_BURST_DEF  = 4;

  typedef enum logic {
    SCH_IDLE = 1'b0,
    SCH_SEND = 1'b1
  } sch_state_e;

endpackage

// File: rtl/vc_output_scheduler_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr.
// Also used by the input-port VC allocator.
module rr_pick
  import vc_output_scheduler_pkg::*;
#(
  parameter int NUM_VC = NUM_VC_DEF,
  localparam int VC_W = $clog2(NUM_VC)
) (
  input  logic [NUM_VC-1:0] req,
  input  logic [VC_W-1:0]   ptr,
  output logic [VC_W-1:0]   gnt_idx,
  output logic              any
);

  logic [VC_W-1:0] idx;

  // Scan farthest offset first so the nearest request wins.
  always_comb begin
    gnt_idx = ptr;
    any     = 1'b0;
    idx     = ptr;
    for (int k = NUM_VC - 1; k >= 0; k--) begin
      idx = ptr + VC_W'(k);
      if (req[idx]) begin
        gnt_idx = idx;
        any     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vc_output_scheduler.sv
// Credit-based round-robin scheduler draining per-VC buffers onto one link.
// Bursts are bounded so one VC cannot starve the rest.
module vc_output_scheduler
  import vc_output_scheduler_pkg::*;
#(
  parameter int NUM_VC     = NUM_VC_DEF,
  parameter int FLIT_W     = FLIT_W_DEF,
  parameter int CREDIT_MAX = CREDIT_MAX_DEF,
  parameter int MAX_BURST  = MAX_BURST_DEF,
  localparam int VC_W  = $clog2(NUM_VC),
  localparam int CNT_W = $clog2(CREDIT_MAX + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_VC-1:0]        vc_empty,
  input  logic [NUM_VC*FLIT_W-1:0] vc_data,
  output logic [NUM_VC-1:0]        vc_read_en,
  input  logic [NUM_VC-1:0]        credit_in,
  output logic                     out_valid,
  output logic [FLIT_W-1:0]        out_data,
  output logic [VC_W-1:0]          out_vc,
  output logic                     credit_err
);

  localparam int BW = $clog2(MAX_BURST + 1);

  sch_state_e        state_q, state_d;
  logic [VC_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [VC_W-1:0]   cur_vc_q, cur_vc_d;
  logic [BW-1:0]     burst_q, burst_d;
  logic [CNT_W-1:0]  credit_q [NUM_VC];
  logic [CNT_W-1:0]  credit_d [NUM_VC];
  logic              out_valid_q, out_valid_d;
  logic [FLIT_W-1:0] out_data_q, out_data_d;
  logic [VC_W-1:0]   out_vc_q, out_vc_d;
  logic              err_q, err_d;

  logic [NUM_VC-1:0] elig;
  logic [VC_W-1:0]   pick_idx;
  logic              pick_any;
  logic [FLIT_W-1:0] sel_data;
  logic              rd;
  logic [BW-1:0]     burst_inc;

  rr_pick #(.NUM_VC(NUM_VC)) u_pick (
    .req    (elig),
    .ptr    (rr_ptr_q),
    .gnt_idx(pick_idx),
    .any    (pick_any)
  );

  always_comb begin
    elig     = ~vc_empty;
    sel_data = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (credit_q[i] == '0) elig[i] = 1'b0;
      if (cur_vc_q == VC_W'(i)) sel_data = vc_data[i*FLIT_W +: FLIT_W];
    end
  end

  // Reset gates the pop so a flit under reset is neither lost nor sent.
  always_comb begin
    vc_read_en = '0;
    if (!reset && state_q == SCH_SEND && elig[cur_vc_q])
      vc_read_en[cur_vc_q] = 1'b1;
  end

  assign rd        = |vc_read_en;
  assign burst_inc = burst_q + BW'(1);

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    cur_vc_d = cur_vc_q;
    burst_d  = burst_q;
    unique case (state_q)
      SCH_IDLE: begin
        if (pick_any) begin
          cur_vc_d = pick_idx;
          burst_d  = '0;
          state_d  = SCH_SEND;
        end
      end
      SCH_SEND: begin
        if (rd) burst_d = burst_inc;
        if (!rd || burst_inc == BW'(MAX_BURST)) begin
          state_d  = SCH_IDLE;
          rr_ptr_d = cur_vc_q + VC_W'(1);
        end
      end
      default: state_d = SCH_IDLE;
    endcase
  end

  always_comb begin
    out_valid_d = rd;
    out_data_d  = rd ? sel_data : out_data_q;
    out_vc_d    = rd ? cur_vc_q : out_vc_q;
    err_d       = err_q;
    for (int i = 0; i < NUM_VC; i++) begin
      credit_d[i] = credit_q[i];
      if (credit_in[i] && !vc_read_en[i]) begin
        if (credit_q[i] == CNT_W'(CREDIT_MAX)) err_d = 1'b1;
        else credit_d[i] = credit_q[i] + CNT_W'(1);
      end else if (!credit_in[i] && vc_read_en[i]) begin
        credit_d[i] = credit_q[i] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= SCH_IDLE;
      rr_ptr_q    <= '0;
      cur_vc_q    <= '0;
      burst_q     <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_vc_q    <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < NUM_VC; i++) credit_q[i] <= CNT_W'(CREDIT_MAX);
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      cur_vc_q    <= cur_vc_d;
      burst_q     <= burst_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_vc_q    <= out_vc_d;
      err_q       <= err_d;
      for (int i = 0; i < NUM_VC; i++) credit_q[i] <= credit_d[i];
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = out_data_q;
  assign out_vc     = out_vc_q;
  assign credit_err = err_q;

endmodule
